// File: rtl/data_relay_fifo_if.sv
// Point-to-point valid/ready link carried through the relay FIFO.
// The producer-facing half (in_*) and consumer-facing half (out_*) share one
// bundle so a parent can wire both sides of the relay with one instance.
interface data_relay_fifo_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;

  // Environment side: drives producer payload and consumer acceptance.
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  // FIFO side.
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/data_relay_fifo.sv
// Registered valid/ready relay FIFO with occupancy, flush and peak monitor.
// First-word-fall-through: the head entry is always presented on data_out.
// count is tracked explicitly so full/empty never alias on pointer equality.
module data_relay_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  data_relay_fifo_if.slave lnk,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] peak_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             next_count;
  logic                         push, pop;

  // Handshake outputs come only from registered state, never from the
  // opposite side's valid/ready, so no combinational path crosses the relay.
  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign lnk.in_ready  = !full;
  assign lnk.out_valid = !empty;
  assign lnk.data_out  = mem[rd_ptr];

  // Flush swallows any transfer offered in the same cycle.
  assign push = lnk.in_valid && !full && !flush;
  assign pop  = lnk.out_ready && !empty && !flush;

  // Occupancy after this edge; feeds both count and the peak monitor.
  always_comb begin
    next_count = count;
    if (flush)
      next_count = '0;
    else if (push && !pop)
      next_count = count + CNT_W'(1);
    else if (!push && pop)
      next_count = count - CNT_W'(1);
  end

  // Pointers, occupancy and peak tracker; power-of-2 depth wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      peak_count <= '0;
    end else begin
      count <= next_count;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        peak_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (next_count > peak_count) peak_count <= next_count;
      end
    end
  end

  // Storage: cleared on reset so data_out reads 0 afterwards; flush leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mem <= '0;
    else if (push)
      mem[wr_ptr] <= lnk.data_in;
  end
endmodule

// File: doc/data_relay_fifo.md
Name: data_relay_fifo

Overview:
Parametrised, registered valid/ready relay between a producer and a consumer module. It is the successor to the fixed 8-bit direct `data_in`/`data_out` hookup, generalised to DATA_W and DEPTH. It adds backpressure, buffering, occupancy reporting, flush and a peak-occupancy monitor. It sits on point-to-point data links between sibling submodules inside a parent module.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- DEPTH, 4, number of storage entries (power of 2, >=2).
- CNT_W, $clog2(DEPTH+1), width of the occupancy outputs (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of contents and peak monitor.
- in_valid  input  1  producer has a word on data_in.
- in_ready  output  1  FIFO can accept a word this cycle.
- data_in  input  DATA_W  producer payload.
- out_valid  output  1  data_out holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- data_out  output  DATA_W  head-of-queue payload.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- peak_count  output  CNT_W  maximum count reached since reset or flush.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, empty=1, full=0, out_valid=0, in_ready=1, peak_count=0.
  - Read/write pointers=0; storage entries cleared to 0, so data_out=0.
- Push: in_valid && in_ready at a rising edge. Writes data_in at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge. rd_ptr increments modulo DEPTH.
- in_ready = !full, combinational from registered state. There is no same-cycle pass-through when full: a pop while full frees space only from the next cycle.
- out_valid = !empty.
- data_out = storage[rd_ptr], first-word-fall-through.
- Latency: a word pushed at edge N is visible on data_out with out_valid=1 right after edge N. It can be popped at edge N+1 at the earliest.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Push when empty combined with out_ready: no pop occurs that cycle, because out_valid was 0.
- Order is strictly first-in first-out; there is no reordering or duplication.
- Pointers use DEPTH-modulo wrap. count is tracked explicitly, so full and empty are never ambiguous.
- in_valid while full: the word is not taken. The producer must hold it; this is not an error.
- data_in and in_valid may change freely while in_ready=0.
- flush (has priority over push and pop in the same cycle):
  - Next cycle: count=0, pointers=0, empty=1, peak_count=0.
  - Any push or pop offered in the flush cycle is discarded.
  - Storage is not cleared, so data_out shows storage[0] but out_valid=0.
- peak_count: registered. Each edge, if next_count > peak_count, peak_count is set to next_count. It saturates at DEPTH.
- Reset asserted mid-transfer: all state is cleared immediately. On release, the first edge behaves as after power-up.
- Outputs never depend combinationally on in_valid or out_ready.

Test Plan (DATA_W=8, DEPTH=4):
1. Reset, then push 0xA1 at edge 1 with out_ready=0 → after edge 1: out_valid=1, data_out=0xA1, count=1, empty=0, peak_count=1.
2. Push 0x01..0x04 on consecutive edges with out_ready=0 → full=1, in_ready=0, count=4. Offer 0x05 for 3 cycles → not accepted. Raise out_ready → pops 0x01,0x02,0x03,0x04 in order, then 0x05 once space frees.
3. Steady stream of 10 words 0x10..0x19 with in_valid=out_ready=1 → count stays at 1 after the first edge. Output order is 0x10..0x19, and the pointers wrap twice.
4. With count=2 (0x30,0x31 queued), assert flush together with in_valid=1 (0x32) and out_ready=1 → next cycle: count=0, empty=1, out_valid=0, peak_count=0. 0x32 is not stored.
5. With count=3, pull rst_n low between clock edges → count=0, out_valid=0, data_out=0, peak_count=0 immediately, without waiting for a clock edge.
6. Fill to 3, drain to 0, fill to 2 → peak_count=3 throughout the second fill. Fill to 4 → peak_count=4.
